// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-ported main memory
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t     state, state_nxt;
  logic       owner_data;
  logic [3:0] streak;
  logic       grant_any;
  logic       grant_data;

  // Data normally wins; a fetch that has waited out the full streak goes first.
  assign grant_any  = f_req || d_req;
  assign grant_data = d_req && !(f_req && (streak == STREAK_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_data <= 1'b0;
      streak     <= 4'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      f_rdata    <= 32'd0;
      d_rdata    <= 32'd0;
    end else begin
      if (state == IDLE && grant_any) begin
        owner_data <= grant_data;
        mem_addr   <= grant_data ? d_addr : f_addr;
        mem_we     <= grant_data && d_we;
        mem_wdata  <= grant_data ? d_wdata : 32'd0;
        if (!grant_data)
          streak <= 4'd0;
        else if (f_req && streak < STREAK_MAX)
          streak <= streak + 4'd1;
      end
      if (state == BUSY && mem_ready) begin
        if (!owner_data)
          f_rdata <= mem_rdata;
        else if (!mem_we)
          d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_req = (state == BUSY);
  assign f_done  = (state == RESP) && !owner_data;
  assign d_done  = (state == RESP) && owner_data;
  assign f_stall = f_req && !f_done;
  assign d_stall = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] f_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        f_done, d_done, f_stall, d_stall, mem_req, mem_we;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_stall(f_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        rdy;
    logic [31:0] rd;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_fdone;
    logic        e_ddone;
    logic [31:0] e_frd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Transaction-level reference: one outstanding access, then a single response cycle.
  bit          m_busy;
  int          m_resp;
  bit          m_own_d;
  bit          m_we;
  logic [31:0] m_addr, m_wd, m_frd, m_drd;
  int          m_streak;

  task automatic model_reset();
    m_busy = 0; m_resp = -1; m_own_d = 0; m_we = 0;
    m_addr = 0; m_wd = 0; m_frd = 0; m_drd = 0; m_streak = 0;
  endtask

  task automatic model_edge();
    if (m_resp != -1) begin
      m_resp = -1;
    end else if (m_busy) begin
      if (mem_ready) begin
        if (!m_own_d)  m_frd = mem_rdata;
        else if (!m_we) m_drd = mem_rdata;
        m_resp = m_own_d ? 1 : 0;
        m_busy = 0;
      end
    end else if (f_req || d_req) begin
      m_own_d = d_req && !(f_req && m_streak == MAX);
      m_addr  = m_own_d ? d_addr : f_addr;
      m_we    = m_own_d && d_we;
      m_wd    = m_own_d ? d_wdata : 32'd0;
      if (!m_own_d)   m_streak = 0;
      else if (f_req) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
      m_busy = 1;
    end
  endtask

  initial begin
    string seq;
    int    n;
    bit    any_done;
    bit    fd_prev, dd_prev;

    #3 rst = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", {f_done, d_done}, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    tbl[0]  = '{1, 32'h10, 0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0,  0, 0, 32'h0,        32'h0};
    tbl[1]  = '{1, 32'h10, 0, 0, 32'h0,  0, 1, 32'hDEADBEEF, 1, 32'h10, 0, 0, 32'h0,        32'h0};
    tbl[2]  = '{1, 32'h10, 0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h10, 1, 0, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{0, 32'h0,  0, 0, 32'h0,  0, 1, 32'h12345678, 0, 32'h10, 0, 0, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1, 32'h30, 1, 0, 32'h20, 0, 0, 32'h0,        0, 32'h10, 0, 0, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1, 32'h30, 1, 0, 32'h20, 0, 1, 32'hA5A5A5A5, 1, 32'h20, 0, 0, 32'hDEADBEEF, 32'h0};
    tbl[6]  = '{1, 32'h30, 1, 0, 32'h20, 0, 1, 32'hFFFF0000, 0, 32'h20, 0, 1, 32'hDEADBEEF, 32'hA5A5A5A5};
    tbl[7]  = '{1, 32'h30, 0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h20, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5};
    tbl[8]  = '{1, 32'h30, 0, 0, 32'h0,  0, 1, 32'h0BADF00D, 1, 32'h30, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5};
    tbl[9]  = '{1, 32'h30, 0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h30, 1, 0, 32'h0BADF00D, 32'hA5A5A5A5};
    tbl[10] = '{0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h30, 0, 0, 32'h0BADF00D, 32'hA5A5A5A5};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      f_req = tbl[i].fr; f_addr = tbl[i].fa; d_req = tbl[i].dr; d_we = tbl[i].dw;
      d_addr = tbl[i].da; d_wdata = tbl[i].dwd; mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rd;
      #2;
      chk($sformatf("vec%0d_mem_req", i), mem_req, tbl[i].e_mreq);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].e_maddr);
      chk($sformatf("vec%0d_mem_we", i), mem_we, 0);
      chk($sformatf("vec%0d_f_done", i), f_done, tbl[i].e_fdone);
      chk($sformatf("vec%0d_d_done", i), d_done, tbl[i].e_ddone);
      chk($sformatf("vec%0d_f_rdata", i), f_rdata, tbl[i].e_frd);
      chk($sformatf("vec%0d_d_rdata", i), d_rdata, tbl[i].e_drd);
      chk($sformatf("vec%0d_f_stall", i), f_stall, tbl[i].fr && !tbl[i].e_fdone);
      chk($sformatf("vec%0d_d_stall", i), d_stall, tbl[i].dr && !tbl[i].e_ddone);
      next_cycle();
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    fd_prev = 0; dd_prev = 0;
    for (int c = 0; c < 600; c++) begin
      if (!f_req || fd_prev) begin
        f_req = ($urandom_range(0, 2) != 0); f_addr = $urandom;
      end
      if (!d_req || dd_prev) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1);
        d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #2;
      chk($sformatf("rnd%0d_mem_req", c), mem_req, m_busy);
      chk($sformatf("rnd%0d_cmd", c), {mem_we, mem_addr}, {m_we, m_addr});
      chk($sformatf("rnd%0d_mem_wdata", c), mem_wdata, m_wd);
      chk($sformatf("rnd%0d_done", c), {f_done, d_done}, {m_resp == 0, m_resp == 1});
      chk($sformatf("rnd%0d_f_rdata", c), f_rdata, m_frd);
      chk($sformatf("rnd%0d_d_rdata", c), d_rdata, m_drd);
      chk($sformatf("rnd%0d_stall", c), {f_stall, d_stall},
          {f_req && !(m_resp == 0), d_req && !(m_resp == 1)});
      fd_prev = (m_resp == 0);
      dd_prev = (m_resp == 1);
      model_edge();
      next_cycle();
    end

    // Streak: fetch waits for MAX data grants, then wins, and the streak restarts.
    do_reset();
    f_req = 1; f_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 1;
    seq = "";
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      #2;
      if (d_done) begin seq = {seq, "D"}; n++; end
      if (f_done) begin seq = {seq, "F"}; n++; end
      next_cycle();
    end
    total++;
    if (seq != "DDFDDF") begin
      bad++;
      $display("FAIL streak_order actual=%s required=DDFDDF", seq);
    end

    // Write with mem_ready delayed: command held steady, single done, d_rdata untouched.
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55; mem_rdata = 32'hCAFEF00D;
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      mem_ready = (k == 5);
      #2;
      chk($sformatf("wr_busy%0d_cmd", k), {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h40});
      chk($sformatf("wr_busy%0d_wdata", k), mem_wdata, 32'h55);
      chk($sformatf("wr_busy%0d_d_done", k), d_done, 0);
      chk($sformatf("wr_busy%0d_d_stall", k), d_stall, 1);
      next_cycle();
    end
    mem_ready = 0;
    #2;
    chk("wr_resp_d_done", d_done, 1);
    chk("wr_resp_mem_req", mem_req, 0);
    chk("wr_resp_d_rdata", d_rdata, 0);
    next_cycle();
    d_req = 0;
    #2;
    chk("wr_after_d_done", d_done, 0);
    next_cycle();

    // Reset in the second BUSY cycle aborts; a later request that drops req still completes.
    do_reset();
    f_req = 1; f_addr = 32'h80;
    next_cycle();
    #2;
    chk("abort_busy1_mem_req", mem_req, 1);
    next_cycle();
    #2;
    rst = 0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_addr", mem_addr, 0);
    f_req = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    mem_ready = 1;
    any_done = 0;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      #2;
      if (f_done || d_done) any_done = 1;
      next_cycle();
    end
    chk("abort_no_done", any_done, 0);
    mem_ready = 0;
    d_req = 1; d_we = 0; d_addr = 32'h44;
    next_cycle();
    d_req = 0;
    #2;
    chk("post_rst_cmd", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h44});
    next_cycle();
    mem_ready = 1; mem_rdata = 32'h600DCAFE;
    next_cycle();
    mem_ready = 0;
    #2;
    chk("post_rst_d_done", d_done, 1);
    chk("post_rst_d_rdata", d_rdata, 32'h600DCAFE);
    chk("post_rst_f_done", f_done, 0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4, meaning the number of consecutive data grants allowed while fetch waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port f_req, input, 1, fetch-stage read request, held until f_done.
REQ-005 SHALL have port f_addr, input, 32, fetch read address, stable while f_req=1.
REQ-006 SHALL have port f_done, output, 1, one-cycle pulse marking fetch access completion.
REQ-007 SHALL have port f_rdata, output, 32, fetch read data, valid when f_done=1.
REQ-008 SHALL have port d_req, input, 1, memory-stage access request, held until d_done.
REQ-009 SHALL have port d_we, input, 1, 1 = write, 0 = read; stable while d_req=1.
REQ-010 SHALL have port d_addr, input, 32, data address, stable while d_req=1.
REQ-011 SHALL have port d_wdata, input, 32, write data, stable while d_req=1.
REQ-012 SHALL have port d_done, output, 1, one-cycle pulse marking data access completion.
REQ-013 SHALL have port d_rdata, output, 32, data read result, valid when d_done=1 and the access was a read.
REQ-014 SHALL have port mem_req, output, 1, request to the single-ported main memory.
REQ-015 SHALL have ports mem_we (1), mem_addr (32) and mem_wdata (32), all outputs, forming the registered command.
REQ-016 SHALL have port mem_rdata, input, 32, memory read data, valid with mem_ready.
REQ-017 SHALL have port mem_ready, input, 1, memory completion strobe, sampled only while mem_req=1.
REQ-018 SHALL have ports f_stall and d_stall, outputs, 1 each, high while the matching req=1 and its done is not pulsing.

Function
REQ-019 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-020 IDLE: if any req=1 at an edge, SHALL latch the winner (owner), address, we and wdata, and go to BUSY; otherwise SHALL stay in IDLE.
REQ-021 BUSY: mem_req=1 with the latched command held constant; on an edge with mem_ready=1, SHALL capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
REQ-022 RESP: SHALL pulse the owner's done for exactly this one cycle and make no arbitration decision; the next state SHALL be IDLE.
REQ-023 Fetch commands SHALL always drive mem_we=0 and mem_wdata=0.
REQ-024 Minimum latency: req in cycle 0, mem_req in cycles 1..k, mem_ready in cycle k, done in cycle k+1; maximum throughput is one access per 3 cycles.
REQ-025 Priority: data SHALL win when both req=1, unless streak==MAX_DATA_STREAK, in which case fetch SHALL win.
REQ-026 streak (4-bit) SHALL increment on a data grant made while f_req=1, saturating at MAX_DATA_STREAK; it SHALL clear on any fetch grant and hold otherwise.
REQ-027 f_rdata and d_rdata SHALL hold their last captured value between accesses; a data write SHALL NOT modify d_rdata.
REQ-028 mem_ready asserted while in IDLE or RESP SHALL be ignored.
REQ-029 A requester dropping req while it owns the access SHALL NOT abort the access; the done pulse still occurs.
REQ-030 A requester may present a new req during its RESP cycle; it SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-031 On rst=0, asynchronously: state=IDLE, streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, f_done=0, d_done=0, f_rdata=0, d_rdata=0.
REQ-032 Reset mid-BUSY SHALL abort the access with no done pulse; operation SHALL resume in IDLE on the first edge after rst=1.

Verification
REQ-033 Fetch only, f_addr=0x10, mem_ready in cycle 1 with mem_rdata=0xDEADBEEF -> mem_addr=0x10, f_done in cycle 2, f_rdata=0xDEADBEEF.
REQ-034 Simultaneous f_req and d_req (read 0x20) -> data served first, d_done first, then fetch granted in the next IDLE.
REQ-035 MAX_DATA_STREAK=2, f_req held with back-to-back d_req -> two data grants, then a fetch grant, streak=0.
REQ-036 Data write of 0x55 to 0x40 with mem_ready delayed 5 cycles -> mem_we=1 and mem_wdata=0x55 stable for 5 cycles, d_done once, d_rdata unchanged.
REQ-037 rst=0 in the second BUSY cycle -> mem_req drops immediately, no done pulse, and a new request after rst=1 completes normally.
REQ-038 Spurious mem_ready in IDLE -> no done pulse and no rdata change.
